// File: rtl/am_lock_rx.sv
// Per-lane alignment-marker lock for a multi-lane 64b/66b receive path.
// Each physical lane locks independently and reports which logical lane it carries.
module am_lock_rx #(
    parameter int LANE_N  = 4,
    parameter int BLOCK_W = 66,
    parameter int AM_GAP  = 16384
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [LANE_N-1:0]           valid_i,
    input  logic [LANE_N*BLOCK_W-1:0]   block_i,
    output logic [LANE_N-1:0]           valid_o,
    output logic [LANE_N*BLOCK_W-1:0]   block_o,
    output logic [LANE_N-1:0]           am_o,
    output logic [LANE_N-1:0]           lock_o,
    output logic [LANE_N*LANE_N-1:0]    lane_o,
    output logic                        lock_all_o
);
    localparam int CNT_W = (AM_GAP > 1) ? $clog2(AM_GAP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AM_GAP - 1);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_CHECK  = 2'd1;
    localparam logic [1:0] ST_LOCK   = 2'd2;

    // Marker bytes packed as {M0, M1, M2}.
    function automatic logic [23:0] am_marker(input logic [1:0] id);
        case (id)
            2'd0:    am_marker = 24'h907647;
            2'd1:    am_marker = 24'hF0C4E6;
            2'd2:    am_marker = 24'hC5659B;
            default: am_marker = 24'hA2793D;
        endcase
    endfunction

    function automatic logic am_match(input logic [BLOCK_W-1:0] b, input logic [1:0] id);
        logic [23:0] m;
        logic [23:0] plain;
        m     = am_marker(id);
        plain = {m[7:0], m[15:8], m[23:16]};
        am_match = (b[1:0] == 2'b10) && (b[25:2] == plain) && (b[57:34] == ~plain);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o <= '0;
            block_o <= '0;
        end else begin
            valid_o <= valid_i;
            block_o <= block_i;
        end
    end

    genvar p;
    generate
        for (p = 0; p < LANE_N; p++) begin : g_lane
            logic [1:0]       state_q;
            logic [1:0]       id_q;
            logic [1:0]       miss_q;
            logic [CNT_W-1:0] cnt_q;
            logic             am_q;
            logic [3:0]       hit;
            logic [1:0]       first_id;
            logic             at_exp;
            logic             own_hit;

            always_comb begin
                hit = '0;
                for (int i = 0; i < 4; i++) begin
                    hit[i] = am_match(block_i[p*BLOCK_W +: BLOCK_W], 2'(i));
                end
            end

            // Marker values are distinct, so at most one id can hit.
            always_comb begin
                first_id = 2'd0;
                for (int i = 3; i >= 0; i--) begin
                    if (hit[i]) first_id = 2'(i);
                end
            end

            assign at_exp  = valid_i[p] && (cnt_q == CNT_LAST);
            assign own_hit = hit[id_q];

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q <= ST_SEARCH;
                    id_q    <= 2'd0;
                    miss_q  <= 2'd0;
                    cnt_q   <= '0;
                    am_q    <= 1'b0;
                end else begin
                    am_q <= (state_q == ST_LOCK) && at_exp && own_hit;
                    if (valid_i[p]) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        case (state_q)
                            ST_SEARCH: begin
                                if (|hit) begin
                                    id_q    <= first_id;
                                    cnt_q   <= '0;
                                    state_q <= ST_CHECK;
                                end
                            end
                            ST_CHECK: begin
                                if (at_exp) begin
                                    cnt_q <= '0;
                                    if (own_hit) begin
                                        miss_q  <= 2'd0;
                                        state_q <= ST_LOCK;
                                    end else begin
                                        id_q    <= 2'd0;
                                        state_q <= ST_SEARCH;
                                    end
                                end
                            end
                            ST_LOCK: begin
                                // Gap counter restarts at every expected slot, hit or miss.
                                if (at_exp) begin
                                    cnt_q <= '0;
                                    if (own_hit) begin
                                        miss_q <= 2'd0;
                                    end else if (miss_q == 2'd3) begin
                                        miss_q  <= 2'd0;
                                        id_q    <= 2'd0;
                                        state_q <= ST_SEARCH;
                                    end else begin
                                        miss_q <= miss_q + 2'd1;
                                    end
                                end
                            end
                            default: state_q <= ST_SEARCH;
                        endcase
                    end
                end
            end

            assign am_o[p]   = am_q;
            assign lock_o[p] = (state_q == ST_LOCK);
            assign lane_o[p*LANE_N +: LANE_N] = (state_q == ST_LOCK)
                ? ({{(LANE_N-1){1'b0}}, 1'b1} << id_q) : '0;
        end
    endgenerate

    // Duplicate ids leave a hole in the OR, which blocks lock_all_o.
    logic [LANE_N-1:0] lane_or;
    always_comb begin
        lane_or = '0;
        for (int i = 0; i < LANE_N; i++) begin
            lane_or = lane_or | lane_o[i*LANE_N +: LANE_N];
        end
    end

    assign lock_all_o = (&lock_o) && (&lane_or);

endmodule

// File: tb/tb_am_lock_rx.sv
// Directed bench for am_lock_rx with a short marker gap of 8 valid blocks.
// Each scenario task drives blocks and checks registered outputs 1 ns after the edge.
module tb_am_lock_rx;
    localparam int LANE_N  = 4;
    localparam int BLOCK_W = 66;
    localparam int AM_GAP  = 8;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic [LANE_N-1:0]          valid_i;
    logic [LANE_N*BLOCK_W-1:0]  block_i;
    logic [LANE_N-1:0]          valid_o;
    logic [LANE_N*BLOCK_W-1:0]  block_o;
    logic [LANE_N-1:0]          am_o;
    logic [LANE_N-1:0]          lock_o;
    logic [LANE_N*LANE_N-1:0]   lane_o;
    logic                       lock_all_o;

    logic [BLOCK_W-1:0]         blk [4];
    logic [LANE_N*BLOCK_W-1:0]  sent;
    int                         cur_id [4];
    int                         errors = 0;
    int                         checks = 0;

    assign block_i = {blk[3], blk[2], blk[1], blk[0]};

    am_lock_rx #(.LANE_N(LANE_N), .BLOCK_W(BLOCK_W), .AM_GAP(AM_GAP)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid_i),
        .block_i    (block_i),
        .valid_o    (valid_o),
        .block_o    (block_o),
        .am_o       (am_o),
        .lock_o     (lock_o),
        .lane_o     (lane_o),
        .lock_all_o (lock_all_o)
    );

    always #5 clk = ~clk;

    function automatic logic [65:0] mk_am(input int id, input logic bad);
        logic [7:0] m0, m1, m2, m1f, bip1, bip2;
        case (id)
            0:       {m0, m1, m2} = 24'h907647;
            1:       {m0, m1, m2} = 24'hF0C4E6;
            2:       {m0, m1, m2} = 24'hC5659B;
            default: {m0, m1, m2} = 24'hA2793D;
        endcase
        m1f  = bad ? ~m1 : m1;
        bip1 = 8'($urandom);
        bip2 = 8'($urandom);
        return {bip2, ~m2, ~m1, ~m0, bip1, m2, m1f, m0, 2'b10};
    endfunction

    function automatic logic [65:0] mk_data();
        return {32'($urandom), 32'($urandom), 2'b01};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [3:0] am_mask, input logic [3:0] bad_mask,
                        input logic [3:0] vmask);
        for (int p = 0; p < 4; p++) begin
            blk[p] = am_mask[p] ? mk_am(cur_id[p], bad_mask[p]) : mk_data();
        end
        valid_i = vmask;
        #0;
        sent = block_i;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(4'h0, 4'h0, 4'h0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cur_id = '{3, 2, 1, 0};
        step(4'hF, 4'h0, 4'hF);
        checks++; if (valid_o !== 4'h0) begin errors++; $display("FAIL reset_valid: got %h exp 0", valid_o); end
        checks++; if (block_o !== '0) begin errors++; $display("FAIL reset_block: got %h exp 0", block_o); end
        checks++; if (am_o !== 4'h0) begin errors++; $display("FAIL reset_am: got %h exp 0", am_o); end
        checks++; if (lock_o !== 4'h0) begin errors++; $display("FAIL reset_lock: got %h exp 0", lock_o); end
        checks++; if (lane_o !== 16'h0) begin errors++; $display("FAIL reset_lane: got %h exp 0", lane_o); end
        checks++; if (lock_all_o !== 1'b0) begin errors++; $display("FAIL reset_lock_all: got %b exp 0", lock_all_o); end
        rst = 1'b0;
    endtask

    task automatic test_lock_all();
        logic [3:0] exp_lock, exp_am;
        do_reset();
        cur_id = '{3, 2, 1, 0};
        for (int k = 0; k <= 24; k++) begin
            step((k % 8 == 0) ? 4'hF : 4'h0, 4'h0, 4'hF);
            exp_lock = (k >= 8) ? 4'hF : 4'h0;
            exp_am   = (k >= 16 && k % 8 == 0) ? 4'hF : 4'h0;
            checks++; if (lock_o !== exp_lock) begin errors++; $display("FAIL lock_all_lock k=%0d: got %h exp %h", k, lock_o, exp_lock); end
            checks++; if (am_o !== exp_am) begin errors++; $display("FAIL lock_all_am k=%0d: got %h exp %h", k, am_o, exp_am); end
        end
        checks++; if (lane_o !== 16'h1248) begin errors++; $display("FAIL lock_all_lane: got %h exp 1248", lane_o); end
        checks++; if (lock_all_o !== 1'b1) begin errors++; $display("FAIL lock_all_flag: got %b exp 1", lock_all_o); end
        checks++; if (valid_o !== 4'hF) begin errors++; $display("FAIL lock_all_valid: got %h exp f", valid_o); end
        checks++; if (block_o !== sent) begin errors++; $display("FAIL lock_all_block: got %h exp %h", block_o, sent); end
    endtask

    // Continues from the fully locked state left by test_lock_all.
    task automatic test_miss();
        logic [3:0] exp_lock, exp_am;
        for (int k = 25; k <= 56; k++) begin
            step((k % 8 == 0) ? 4'hF : 4'h0, (k % 8 == 0) ? 4'h1 : 4'h0, 4'hF);
            if (k % 8 == 0) begin
                exp_lock = (k < 56) ? 4'hF : 4'hE;
                exp_am   = 4'hE;
                checks++; if (lock_o !== exp_lock) begin errors++; $display("FAIL miss_lock k=%0d: got %h exp %h", k, lock_o, exp_lock); end
                checks++; if (am_o !== exp_am) begin errors++; $display("FAIL miss_am k=%0d: got %h exp %h", k, am_o, exp_am); end
            end
        end
        checks++; if (lane_o !== 16'h1240) begin errors++; $display("FAIL miss_lane: got %h exp 1240", lane_o); end
        checks++; if (lock_all_o !== 1'b0) begin errors++; $display("FAIL miss_lock_all: got %b exp 0", lock_all_o); end
    endtask

    task automatic test_id_switch();
        do_reset();
        cur_id = '{3, 2, 1, 0};
        for (int k = 0; k <= 24; k++) begin
            cur_id[1] = (k == 0) ? 2 : 3;
            step((k % 8 == 0) ? 4'b0010 : 4'h0, 4'h0, 4'hF);
            if (k == 8 || k == 16) begin
                checks++; if (lock_o !== 4'h0) begin errors++; $display("FAIL id_switch_lock k=%0d: got %h exp 0", k, lock_o); end
            end
            if (k == 24) begin
                checks++; if (lock_o !== 4'b0010) begin errors++; $display("FAIL id_switch_relock: got %h exp 2", lock_o); end
                checks++; if (lane_o !== 16'h0080) begin errors++; $display("FAIL id_switch_lane: got %h exp 0080", lane_o); end
            end
        end
    endtask

    // Lane 2 only; invalid cycles carry a matching marker that must be ignored.
    task automatic test_valid_gap();
        logic is_am;
        do_reset();
        cur_id = '{3, 2, 1, 0};
        for (int v = 0; v <= 64; v++) begin
            if (v == 32) begin
                step(4'b0100, 4'h0, 4'h0);
                checks++; if (lock_o !== 4'b0100) begin errors++; $display("FAIL gap_shift_lock: got %h exp 4", lock_o); end
            end
            is_am = (v < 40) ? (v % 8 == 0) : (v == 41);
            step(is_am ? 4'b0100 : 4'h0, 4'h0, 4'b0100);
            if (v == 7) begin
                checks++; if (lock_o !== 4'h0) begin errors++; $display("FAIL gap_prelock: got %h exp 0", lock_o); end
            end
            if (v == 8) begin
                checks++; if (lock_o !== 4'b0100) begin errors++; $display("FAIL gap_lock: got %h exp 4", lock_o); end
                checks++; if (valid_o !== 4'b0100) begin errors++; $display("FAIL gap_valid: got %h exp 4", valid_o); end
            end
            if (v == 16 || v == 24 || v == 32) begin
                checks++; if (am_o !== 4'b0100) begin errors++; $display("FAIL gap_am v=%0d: got %h exp 4", v, am_o); end
            end
            if (v == 40 || v == 41) begin
                checks++; if (am_o !== 4'h0) begin errors++; $display("FAIL gap_late_am v=%0d: got %h exp 0", v, am_o); end
            end
            if (v == 56) begin
                checks++; if (lock_o !== 4'b0100) begin errors++; $display("FAIL gap_third_miss: got %h exp 4", lock_o); end
            end
            if (v == 64) begin
                checks++; if (lock_o !== 4'h0) begin errors++; $display("FAIL gap_fourth_miss: got %h exp 0", lock_o); end
            end
            step(4'b0100, 4'h0, 4'h0);
            if (v == 16) begin
                checks++; if (am_o !== 4'h0) begin errors++; $display("FAIL gap_invalid_am: got %h exp 0", am_o); end
                checks++; if (valid_o !== 4'h0) begin errors++; $display("FAIL gap_invalid_valid: got %h exp 0", valid_o); end
            end
        end
    endtask

    task automatic test_dup_id();
        do_reset();
        cur_id = '{0, 0, 1, 2};
        for (int k = 0; k <= 8; k++) begin
            step((k % 8 == 0) ? 4'hF : 4'h0, 4'h0, 4'hF);
        end
        checks++; if (lock_o !== 4'hF) begin errors++; $display("FAIL dup_lock: got %h exp f", lock_o); end
        checks++; if (lane_o !== 16'h4211) begin errors++; $display("FAIL dup_lane: got %h exp 4211", lane_o); end
        checks++; if (lock_all_o !== 1'b0) begin errors++; $display("FAIL dup_lock_all: got %b exp 0", lock_all_o); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cur_id = '{3, 2, 1, 0};
        for (int k = 0; k <= 8; k++) begin
            step((k % 8 == 0) ? 4'hF : 4'h0, 4'h0, 4'hF);
        end
        checks++; if (lock_all_o !== 1'b1) begin errors++; $display("FAIL mid_prelock: got %b exp 1", lock_all_o); end
        rst = 1'b1;
        step(4'h0, 4'h0, 4'hF);
        rst = 1'b0;
        checks++; if (valid_o !== 4'h0) begin errors++; $display("FAIL mid_valid: got %h exp 0", valid_o); end
        checks++; if (block_o !== '0) begin errors++; $display("FAIL mid_block: got %h exp 0", block_o); end
        checks++; if (lock_o !== 4'h0) begin errors++; $display("FAIL mid_lock: got %h exp 0", lock_o); end
        checks++; if (lane_o !== 16'h0) begin errors++; $display("FAIL mid_lane: got %h exp 0", lane_o); end
        checks++; if (lock_all_o !== 1'b0) begin errors++; $display("FAIL mid_lock_all: got %b exp 0", lock_all_o); end
        for (int k = 0; k <= 8; k++) begin
            step((k % 8 == 0) ? 4'hF : 4'h0, 4'h0, 4'hF);
            if (k == 0 || k == 7) begin
                checks++; if (lock_o !== 4'h0) begin errors++; $display("FAIL mid_relock_early k=%0d: got %h exp 0", k, lock_o); end
            end
        end
        checks++; if (lock_o !== 4'hF) begin errors++; $display("FAIL mid_relock: got %h exp f", lock_o); end
        checks++; if (lock_all_o !== 1'b1) begin errors++; $display("FAIL mid_relock_all: got %b exp 1", lock_all_o); end
    endtask

    initial begin
        valid_i = '0;
        for (int p = 0; p < 4; p++) blk[p] = '0;
        test_reset();
        test_lock_all();
        test_miss();
        test_id_switch();
        test_valid_gap();
        test_dup_id();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
